// File: rtl/cpu_wait_sequencer.sv
// cpu_wait_sequencer: generates the 6502 phi2 (sys_clk) and VIA clock
// (via_clk) from the master clock after a power-on hold. It stretches the
// sys_clk high phase for slow I/O windows in the I/O page, using
// CPU-programmable wait counts at IO_PAGE:70..73.
// Optional build macro CPU_WAIT_READBACK_EN adds read access to the wait
// registers through dat_out/dat_oe.
module cpu_wait_sequencer #(
    parameter int unsigned POR_BITS  = 16,
    parameter int unsigned WAIT_BITS = 4,
    parameter logic [7:0]  IO_PAGE   = 8'h9F,
    parameter int unsigned WAIT0_RST = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           adr_hi,
    input  logic [7:0]           adr_lo,
    input  logic                 rw,
    input  logic [7:0]           dat_bus,
    output logic                 sys_clk,
    output logic                 via_clk,
    output logic                 running,
    output logic                 stretching,
    output logic [1:0]           wait_slot
`ifdef CPU_WAIT_READBACK_EN
    ,
    output logic [7:0]           dat_out,
    output logic                 dat_oe
`endif
);

    localparam int unsigned NUM_SLOTS = 4;

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_LOW   = 2'd1,
        ST_HIGH  = 2'd2,
        ST_WAITH = 2'd3
    } state_t;

    state_t                 state;
    logic [POR_BITS-1:0]    por_cnt;
    logic [WAIT_BITS-1:0]   wait_cnt;
    logic [WAIT_BITS-1:0]   wait_reg [NUM_SLOTS];

    logic                   io_page_hit;
    logic [NUM_SLOTS-1:0]   slot_hit;
    logic                   slot_any;
    logic [1:0]             slot_idx;
    logic [WAIT_BITS-1:0]   sel_wait;
    logic                   cfg_hit;
    logic [1:0]             cfg_idx;
    logic                   leave_high;
    logic                   unused_dat_bits;

    // Only the low WAIT_BITS of the data bus are stored.
    assign unused_dat_bits = ^dat_bus;

    // Address decode of the slow I/O windows and the config registers.
    always_comb begin
        io_page_hit = (adr_hi == IO_PAGE);
        slot_hit    = '0;
        slot_hit[0] = io_page_hit && (adr_lo[7:1] == 7'h20);
        slot_hit[1] = io_page_hit && (adr_lo[7:4] == 4'h6);
        slot_hit[2] = io_page_hit && (adr_lo[7:5] == 3'b000);
        slot_hit[3] = io_page_hit && (adr_lo[7:5] == 3'b001);
        slot_any    = |slot_hit;
        slot_idx    = 2'd0;
        if (slot_hit[1]) slot_idx = 2'd1;
        if (slot_hit[2]) slot_idx = 2'd2;
        if (slot_hit[3]) slot_idx = 2'd3;
        sel_wait    = wait_reg[slot_idx];
        cfg_hit     = io_page_hit && (adr_lo[7:2] == 6'b0111_00);
        cfg_idx     = adr_lo[1:0];
    end

    // True on the edge that ends the sys_clk high phase.
    always_comb begin
        leave_high = ((state == ST_HIGH) && (wait_cnt == '0)) ||
                     ((state == ST_WAITH) && (wait_cnt == WAIT_BITS'(1)));
    end

    // Power-on hold, clock generation and wait-state sequencing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_HOLD;
            por_cnt    <= '0;
            running    <= 1'b0;
            sys_clk    <= 1'b0;
            via_clk    <= 1'b0;
            stretching <= 1'b0;
            wait_slot  <= 2'd0;
            wait_cnt   <= '0;
        end else begin
            if (!running) begin
                por_cnt <= por_cnt + POR_BITS'(1);
                if (&por_cnt) begin
                    running <= 1'b1;
                    state   <= ST_LOW;
                end
            end

            via_clk <= running ? ~via_clk : 1'b0;

            case (state)
                ST_HOLD: begin
                    sys_clk <= 1'b0;
                end
                ST_LOW: begin
                    // Start of high phase: sample address, arm the stretch.
                    state   <= ST_HIGH;
                    sys_clk <= 1'b1;
                    if (slot_any && (sel_wait != '0)) begin
                        wait_cnt  <= sel_wait;
                        wait_slot <= slot_idx;
                    end else begin
                        wait_cnt  <= '0;
                    end
                end
                ST_HIGH: begin
                    if (wait_cnt != '0) begin
                        state      <= ST_WAITH;
                        stretching <= 1'b1;
                    end else begin
                        state      <= ST_LOW;
                        sys_clk    <= 1'b0;
                    end
                end
                ST_WAITH: begin
                    wait_cnt <= wait_cnt - WAIT_BITS'(1);
                    if (wait_cnt == WAIT_BITS'(1)) begin
                        state      <= ST_LOW;
                        sys_clk    <= 1'b0;
                        stretching <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_HOLD;
                    sys_clk <= 1'b0;
                end
            endcase
        end
    end

    // Wait-count config registers, written as the CPU write cycle ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_reg[0] <= WAIT_BITS'(WAIT0_RST);
            for (int i = 1; i < NUM_SLOTS; i++) begin
                wait_reg[i] <= '0;
            end
        end else if (leave_high && !rw && cfg_hit) begin
            wait_reg[cfg_idx] <= dat_bus[WAIT_BITS-1:0];
        end
    end

`ifdef CPU_WAIT_READBACK_EN
    logic stay_high;

    // sys_clk is high after this edge.
    always_comb begin
        stay_high = (state == ST_LOW) ||
                    ((state == ST_HIGH) && (wait_cnt != '0)) ||
                    ((state == ST_WAITH) && (wait_cnt != WAIT_BITS'(1)));
    end

    // Config register readback, aligned with the sys_clk high phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dat_oe  <= 1'b0;
            dat_out <= 8'h00;
        end else if (stay_high && rw && cfg_hit) begin
            dat_oe  <= 1'b1;
            dat_out <= 8'(wait_reg[cfg_idx]);
        end else begin
            dat_oe  <= 1'b0;
            dat_out <= 8'h00;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_wait_sequencer.sv
// Directed testbench for cpu_wait_sequencer (POR_BITS=4): a vector table of
// CPU accesses with hand-computed high-phase lengths, plus power-on and
// mid-stretch reset sequences.
module tb_cpu_wait_sequencer;

    logic       clk;
    logic       rst;
    logic [7:0] adr_hi;
    logic [7:0] adr_lo;
    logic       rw;
    logic [7:0] dat_bus;
    logic       sys_clk;
    logic       via_clk;
    logic       running;
    logic       stretching;
    logic [1:0] wait_slot;
`ifdef CPU_WAIT_READBACK_EN
    logic [7:0] dat_out;
    logic       dat_oe;
`endif

    int total;
    int bad;

    cpu_wait_sequencer #(
        .POR_BITS (4),
        .WAIT_BITS(4),
        .IO_PAGE  (8'h9F),
        .WAIT0_RST(3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .adr_hi    (adr_hi),
        .adr_lo    (adr_lo),
        .rw        (rw),
        .dat_bus   (dat_bus),
        .sys_clk   (sys_clk),
        .via_clk   (via_clk),
        .running   (running),
        .stretching(stretching),
        .wait_slot (wait_slot)
`ifdef CPU_WAIT_READBACK_EN
        ,
        .dat_out   (dat_out),
        .dat_oe    (dat_oe)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] ah;
        logic [7:0] al;
        logic       rw;
        logic [7:0] dat;
        int         hi;
        int         str;
        logic [1:0] slot;
        logic       rd_chk;
        logic [7:0] rd_val;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // From reset release: count clocks to running, then check the first clock pair.
    task automatic por_check();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!running && n < 100);
        chk("por_len", n, 16);
        chk("por_sys0", int'(sys_clk), 0);
        chk("por_via0", int'(via_clk), 0);
        @(negedge clk);
        chk("start_sys1", int'(sys_clk), 1);
        chk("start_via1", int'(via_clk), 1);
        @(negedge clk);
        chk("start_sys2", int'(sys_clk), 0);
        chk("start_via2", int'(via_clk), 0);
        @(negedge clk);
        chk("start_sys3", int'(sys_clk), 1);
        chk("start_via3", int'(via_clk), 1);
        @(negedge clk);
        chk("start_sys4", int'(sys_clk), 0);
    endtask

    // One CPU access, started at a negedge in the low phase.
    task automatic run_vec(input int idx, input vec_t v);
        int hi;
        int str;
        adr_hi  = v.ah;
        adr_lo  = v.al;
        rw      = v.rw;
        dat_bus = v.dat;
        hi  = 0;
        str = 0;
        @(negedge clk);
        while (sys_clk && hi < 40) begin
            hi++;
            if (stretching) str++;
`ifdef CPU_WAIT_READBACK_EN
            chk($sformatf("v%0d_dat_oe", idx), int'(dat_oe), int'(v.rd_chk));
            chk($sformatf("v%0d_dat_out", idx), int'(dat_out),
                v.rd_chk ? int'(v.rd_val) : 0);
`endif
            @(negedge clk);
        end
        chk($sformatf("v%0d_high_len", idx), hi, v.hi);
        chk($sformatf("v%0d_stretch_len", idx), str, v.str);
        chk($sformatf("v%0d_wait_slot", idx), int'(wait_slot), int'(v.slot));
        chk($sformatf("v%0d_stretch_low", idx), int'(stretching), 0);
`ifdef CPU_WAIT_READBACK_EN
        chk($sformatf("v%0d_oe_low", idx), int'(dat_oe), 0);
`endif
    endtask

    initial begin
        vec_t v;
        int   j;
        total = 0;
        bad   = 0;
        //            ah     al     rw    dat    hi  str slot  rdchk rdval
        vecs[0]  = '{8'h9F, 8'h40, 1'b1, 8'h00, 4,  3,  2'd0, 1'b0, 8'h00};
        vecs[1]  = '{8'h9F, 8'h72, 1'b0, 8'h05, 1,  0,  2'd0, 1'b0, 8'h00};
        vecs[2]  = '{8'h9F, 8'h10, 1'b1, 8'h00, 6,  5,  2'd2, 1'b0, 8'h00};
        vecs[3]  = '{8'h9F, 8'h70, 1'b1, 8'h00, 1,  0,  2'd2, 1'b1, 8'h03};
        vecs[4]  = '{8'h9F, 8'h70, 1'b0, 8'h00, 1,  0,  2'd2, 1'b0, 8'h00};
        vecs[5]  = '{8'h9F, 8'h41, 1'b1, 8'h00, 1,  0,  2'd2, 1'b0, 8'h00};
        vecs[6]  = '{8'h9F, 8'h71, 1'b0, 8'h0F, 1,  0,  2'd2, 1'b0, 8'h00};
        vecs[7]  = '{8'h9F, 8'h65, 1'b1, 8'h00, 16, 15, 2'd1, 1'b0, 8'h00};
        vecs[8]  = '{8'h9F, 8'h75, 1'b0, 8'h0A, 1,  0,  2'd1, 1'b0, 8'h00};
        vecs[9]  = '{8'h9F, 8'h20, 1'b1, 8'h00, 1,  0,  2'd1, 1'b0, 8'h00};
        vecs[10] = '{8'h9F, 8'h73, 1'b0, 8'h07, 1,  0,  2'd1, 1'b0, 8'h00};
        vecs[11] = '{8'h9F, 8'h73, 1'b1, 8'h00, 1,  0,  2'd1, 1'b1, 8'h07};
        vecs[12] = '{8'h9F, 8'h3F, 1'b1, 8'h00, 8,  7,  2'd3, 1'b0, 8'h00};
        vecs[13] = '{8'h8F, 8'h40, 1'b1, 8'h00, 1,  0,  2'd3, 1'b0, 8'h00};
        vecs[14] = '{8'h9F, 8'h50, 1'b1, 8'h00, 1,  0,  2'd3, 1'b0, 8'h00};
        vecs[15] = '{8'h9F, 8'h72, 1'b1, 8'h00, 1,  0,  2'd3, 1'b1, 8'h05};
        vecs[16] = '{8'h9F, 8'h70, 1'b0, 8'h16, 1,  0,  2'd3, 1'b0, 8'h00};
        vecs[17] = '{8'h9F, 8'h40, 1'b1, 8'h00, 7,  6,  2'd0, 1'b0, 8'h00};
        vecs[18] = '{8'h9F, 8'h71, 1'b1, 8'h00, 1,  0,  2'd0, 1'b1, 8'h0F};
        vecs[19] = '{8'h9F, 8'h65, 1'b1, 8'h00, 16, 15, 2'd1, 1'b0, 8'h00};

        rst     = 1'b1;
        adr_hi  = 8'h00;
        adr_lo  = 8'h00;
        rw      = 1'b1;
        dat_bus = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_sys_clk", int'(sys_clk), 0);
        chk("rst_via_clk", int'(via_clk), 0);
        chk("rst_running", int'(running), 0);
        chk("rst_stretching", int'(stretching), 0);
        chk("rst_wait_slot", int'(wait_slot), 0);
`ifdef CPU_WAIT_READBACK_EN
        chk("rst_dat_oe", int'(dat_oe), 0);
        chk("rst_dat_out", int'(dat_out), 0);
`endif
        rst = 1'b0;
        por_check();

        for (int i = 0; i < NVEC; i++) begin
            run_vec(i, vecs[i]);
        end

        // Reset in the middle of a slot-0 stretch (wait[0]=6), at wait_cnt=2.
        adr_hi = 8'h9F;
        adr_lo = 8'h40;
        rw     = 1'b1;
        j = 0;
        repeat (6) begin
            @(negedge clk);
            j++;
        end
        chk("mid_sys_clk", int'(sys_clk), 1);
        chk("mid_stretching", int'(stretching), 1);
        #1 rst = 1'b1;
        #1;
        chk("async_sys_clk", int'(sys_clk), 0);
        chk("async_via_clk", int'(via_clk), 0);
        chk("async_stretching", int'(stretching), 0);
        chk("async_running", int'(running), 0);
        adr_hi = 8'h00;
        adr_lo = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        por_check();

        // wait[0] back to its reset value, wait[2] back to 0.
        v = '{8'h9F, 8'h40, 1'b1, 8'h00, 4, 3, 2'd0, 1'b0, 8'h00};
        run_vec(100, v);
        v = '{8'h9F, 8'h10, 1'b1, 8'h00, 1, 0, 2'd0, 1'b0, 8'h00};
        run_vec(101, v);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
